// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants for the CP0 interrupt controller.
//               - CP0 register numbers
//               - SR and Cause field bit positions
//               - Exception code enumeration
// Revision    : 1.0  initial release
// ============================================================================
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] C_REG_COUNT   = 5'd9;
    localparam logic [4:0] C_REG_COMPARE = 5'd11;
    localparam logic [4:0] C_REG_SR      = 5'd12;
    localparam logic [4:0] C_REG_CAUSE   = 5'd13;
    localparam logic [4:0] C_REG_EPC     = 5'd14;
    localparam logic [4:0] C_REG_PRID    = 5'd15;

    // SR field positions
    localparam int C_SR_IE    = 0;
    localparam int C_SR_EXL   = 1;
    localparam int C_SR_IM_LO = 10;

    // Cause field positions (IP shares the IM bit positions)
    localparam int C_CAUSE_EXC_LO = 2;
    localparam int C_CAUSE_IP_LO  = 10;
    localparam int C_CAUSE_BD     = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage : cp0_pkg
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer
// Description : CP0 Count/Compare timer. Count free-runs and wraps; the
//               flag sets on the edge after Count==Compare and is cleared
//               by a write to Compare (the clear wins over a same-cycle set).
// Ports       : clk_i          clock, rising edge
//               rst_ni         asynchronous active-low reset
//               we_count_i     write strobe for Count
//               we_compare_i   write strobe for Compare
//               wd_i           write data
//               count_o        current Count
//               compare_o      current Compare
//               flag_o         timer interrupt flag
// Revision    : 1.0  initial release
// ============================================================================
module cp0_timer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_count_i,
    input  logic        we_compare_i,
    input  logic [31:0] wd_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        flag_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [31:0] compare_q;
    logic [31:0] compare_d;
    logic        flag_q;
    logic        flag_d;

    always_comb begin
        count_d   = we_count_i ? wd_i : count_q + 32'd1;
        compare_d = we_compare_i ? wd_i : compare_q;
        flag_d    = flag_q;
        if (we_compare_i) begin
            flag_d = 1'b0;
        end else if (count_q == compare_q) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= 32'h0000_0000;
            compare_q <= 32'hFFFF_FFFF;
            flag_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            flag_q    <= flag_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign flag_o    = flag_q;

endmodule : cp0_timer
`default_nettype wire

// File: rtl/cp0_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cp0_int_ctrl
// Description : MIPS-style CP0 interrupt/exception controller with SR,
//               Cause, EPC, PRId and (optionally) Count/Compare.
//               Build macro CP0_TIMER_EN adds the cp0_timer sub-module and
//               one extra interrupt line (IP/IM bit 10+NUM_HWINT).
// Parameters  : NUM_HWINT  hardware interrupt lines (1..8, 1..7 with timer)
//               PRID_VAL   read-only processor ID
// Ports       : clk        clock, rising edge
//               reset      asynchronous active-low reset
//               A1 / RD    read register number / combinational read data
//               A2/WD/WE   mtc0 register number / data / enable
//               PC, BD     victim PC and delay-slot flag from M stage
//               ExcCode    synchronous exception code
//               EXLSet     synchronous exception request
//               EXLClr     eret, clears EXL
//               HWInt      level interrupt lines
//               IntReq     take exception now (combinational)
//               EPC        EPC register
// Revision    : 1.0  initial release
// ============================================================================
module cp0_int_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID_VAL  = 32'h0000_1234
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           A1,
    input  logic [4:0]           A2,
    input  logic [31:0]          WD,
    input  logic                 WE,
    input  logic [31:0]          PC,
    input  logic                 BD,
    input  logic [4:0]           ExcCode,
    input  logic                 EXLSet,
    input  logic                 EXLClr,
    input  logic [NUM_HWINT-1:0] HWInt,
    output logic                 IntReq,
    output logic [31:0]          EPC,
    output logic [31:0]          RD
);

`ifdef CP0_TIMER_EN
    localparam int NUM_IP = NUM_HWINT + 1;
`else
    localparam int NUM_IP = NUM_HWINT;
`endif

    // Architectural state
    logic [NUM_IP-1:0]    im_q;
    logic [NUM_IP-1:0]    im_d;
    logic                 exl_q;
    logic                 exl_d;
    logic                 ie_q;
    logic                 ie_d;
    logic                 bd_q;
    logic                 bd_d;
    logic [4:0]           exc_q;
    logic [4:0]           exc_d;
    logic [31:0]          epc_q;
    logic [31:0]          epc_d;
    logic [NUM_HWINT-1:0] hwip_q;

    logic [NUM_IP-1:0]    w_ip;
    logic                 w_int_pending;
    logic                 w_intreq;
    logic                 w_wr_en;
    logic                 w_wr_sr;
    logic                 w_wr_epc;
    logic [31:0]          w_sr;
    logic [31:0]          w_cause;
    logic [31:0]          w_count;
    logic [31:0]          w_compare;
    logic                 w_unused_pc;

    // Word-aligned EPC never stores PC[1:0]
    assign w_unused_pc = ^PC[1:0];

    // An exception taken on this edge discards any concurrent mtc0
    assign w_wr_en  = WE & ~w_intreq;
    assign w_wr_sr  = w_wr_en & (A2 == C_REG_SR);
    assign w_wr_epc = w_wr_en & (A2 == C_REG_EPC);

`ifdef CP0_TIMER_EN
    logic w_timer_flag;

    cp0_timer u_timer (
        .clk_i        (clk),
        .rst_ni       (reset),
        .we_count_i   (w_wr_en & (A2 == C_REG_COUNT)),
        .we_compare_i (w_wr_en & (A2 == C_REG_COMPARE)),
        .wd_i         (WD),
        .count_o      (w_count),
        .compare_o    (w_compare),
        .flag_o       (w_timer_flag)
    );

    assign w_ip = {w_timer_flag, hwip_q};
`else
    assign w_count   = 32'h0000_0000;
    assign w_compare = 32'h0000_0000;
    assign w_ip      = hwip_q;
`endif

    assign w_int_pending = (|(w_ip & im_q)) & ie_q & ~exl_q;

    // Gating with reset keeps IntReq low while EXLSet is held during reset
    assign w_intreq = reset & (w_int_pending | (EXLSet & ~exl_q));
    assign IntReq   = w_intreq;
    assign EPC      = epc_q;

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        if (w_intreq) begin
            epc_d = {PC[31:2], 2'b00};
            bd_d  = BD;
            exl_d = 1'b1;
            // A pending interrupt outranks the synchronous exception
            exc_d = w_int_pending ? 5'(EXC_INT) : ExcCode;
        end else begin
            if (w_wr_sr) begin
                im_d  = WD[C_SR_IM_LO +: NUM_IP];
                exl_d = WD[C_SR_EXL];
                ie_d  = WD[C_SR_IE];
            end
            if (w_wr_epc) begin
                epc_d = {WD[31:2], 2'b00};
            end
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q   <= '0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            exc_q  <= 5'd0;
            epc_q  <= 32'h0000_0000;
            hwip_q <= '0;
        end else begin
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            bd_q   <= bd_d;
            exc_q  <= exc_d;
            epc_q  <= epc_d;
            hwip_q <= HWInt;
        end
    end

    // Read path: no bypass, a same-cycle write is seen next cycle
    always_comb begin
        w_sr                             = 32'h0000_0000;
        w_sr[C_SR_IM_LO +: NUM_IP]       = im_q;
        w_sr[C_SR_EXL]                   = exl_q;
        w_sr[C_SR_IE]                    = ie_q;

        w_cause                          = 32'h0000_0000;
        w_cause[C_CAUSE_BD]              = bd_q;
        w_cause[C_CAUSE_IP_LO +: NUM_IP] = w_ip;
        w_cause[C_CAUSE_EXC_LO +: 5]     = exc_q;

        case (A1)
            C_REG_SR:      RD = w_sr;
            C_REG_CAUSE:   RD = w_cause;
            C_REG_EPC:     RD = epc_q;
            C_REG_PRID:    RD = PRID_VAL;
            C_REG_COUNT:   RD = w_count;
            C_REG_COMPARE: RD = w_compare;
            default:       RD = 32'h0000_0000;
        endcase
    end

endmodule : cp0_int_ctrl
`default_nettype wire

// File: tb/tb_cp0_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_int_ctrl
// Description : Self-checking bench for cp0_int_ctrl. Directed scenarios
//               (interrupt entry, masking, write collision, synchronous
//               exception/eret, asynchronous reset) followed by random
//               traffic compared against a word-level reference model.
//               Honours CP0_TIMER_EN when the design is built with it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cp0_int_ctrl;
    import cp0_pkg::*;

    localparam int          NUM_HWINT = 6;
    localparam logic [31:0] PRID_VAL  = 32'h0000_1234;
`ifdef CP0_TIMER_EN
    localparam int NUM_IP = NUM_HWINT + 1;
`else
    localparam int NUM_IP = NUM_HWINT;
`endif
    localparam logic [31:0] IM_MASK = ((32'd1 << NUM_IP) - 32'd1) << 10;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b1;
    logic [4:0]           A1;
    logic [4:0]           A2;
    logic [31:0]          WD;
    logic                 WE;
    logic [31:0]          PC;
    logic                 BD;
    logic [4:0]           ExcCode;
    logic                 EXLSet;
    logic                 EXLClr;
    logic [NUM_HWINT-1:0] HWInt;
    logic                 IntReq;
    logic [31:0]          EPC;
    logic [31:0]          RD;

    int n_tests = 0;
    int n_fail  = 0;

    cp0_int_ctrl #(
        .NUM_HWINT (NUM_HWINT),
        .PRID_VAL  (PRID_VAL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .A1      (A1),
        .A2      (A2),
        .WD      (WD),
        .WE      (WE),
        .PC      (PC),
        .BD      (BD),
        .ExcCode (ExcCode),
        .EXLSet  (EXLSet),
        .EXLClr  (EXLClr),
        .HWInt   (HWInt),
        .IntReq  (IntReq),
        .EPC     (EPC),
        .RD      (RD)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (whole-word view) ----------------
    logic [31:0]          m_sr;
    logic                 m_bd;
    logic [4:0]           m_exc;
    logic [31:0]          m_epc;
    logic [NUM_HWINT-1:0] m_hw;
`ifdef CP0_TIMER_EN
    logic [31:0]          m_count;
    logic [31:0]          m_compare;
    logic                 m_flag;
`endif

    function automatic logic [31:0] ip_word();
        logic [31:0] w;
        w = 32'(m_hw) << 10;
`ifdef CP0_TIMER_EN
        if (m_flag) w = w | (32'd1 << (10 + NUM_HWINT));
`endif
        return w;
    endfunction

    function automatic logic exp_pending();
        return ((ip_word() & m_sr & IM_MASK) != 32'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic exp_intreq();
        return reset && (exp_pending() || (EXLSet && !m_sr[1]));
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return (32'(m_bd) << 31) | ip_word() | (32'(m_exc) << 2);
            5'd14:   return m_epc;
            5'd15:   return PRID_VAL;
`ifdef CP0_TIMER_EN
            5'd9:    return m_count;
            5'd11:   return m_compare;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_sr  = 32'd0;
        m_bd  = 1'b0;
        m_exc = 5'd0;
        m_epc = 32'd0;
        m_hw  = '0;
`ifdef CP0_TIMER_EN
        m_count   = 32'd0;
        m_compare = 32'hFFFF_FFFF;
        m_flag    = 1'b0;
`endif
    endtask

    // Applies one rising edge to the model using the inputs now held.
    task automatic model_edge();
        logic take;
        logic pend;
        logic wr;
        take = exp_intreq();
        pend = exp_pending();
        wr   = WE && !take;
`ifdef CP0_TIMER_EN
        begin
            logic [31:0] cnt_old;
            cnt_old   = m_count;
            m_count   = (wr && A2 == 5'd9) ? WD : m_count + 32'd1;
            if (wr && A2 == 5'd11) begin
                m_compare = WD;
                m_flag    = 1'b0;
            end else if (cnt_old == m_compare) begin
                m_flag = 1'b1;
            end
        end
`endif
        if (take) begin
            m_epc   = PC & 32'hFFFF_FFFC;
            m_bd    = BD;
            m_sr[1] = 1'b1;
            m_exc   = pend ? 5'd0 : ExcCode;
        end else begin
            if (wr && A2 == 5'd12) m_sr = WD & (IM_MASK | 32'd3);
            if (wr && A2 == 5'd14) m_epc = WD & 32'hFFFF_FFFC;
            if (EXLClr) m_sr[1] = 1'b0;
        end
        m_hw = HWInt;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs set; checks mid-cycle, then crosses one edge.
    task automatic cycle(input string tag);
        #4;
        check({tag, "_intreq"}, 32'(IntReq), 32'(exp_intreq()));
        check({tag, "_epc"},    EPC,         m_epc);
        check({tag, "_rd"},     RD,          exp_rd(A1));
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset away from any edge and verifies the reset state with no clock.
    task automatic do_reset();
        logic [4:0] regs [6];
        regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_intreq", 32'(IntReq), 32'd0);
        check("rst_epc",    EPC,         32'd0);
        foreach (regs[k]) begin
            A1 = regs[k];
            #1;
            check("rst_rd", RD, exp_rd(A1));
        end
        WE     = 1'b0;
        EXLSet = 1'b0;
        EXLClr = 1'b0;
        HWInt  = '0;
        A1     = 5'd12;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] rsel [8];
        logic [4:0] esel [5];
        rsel = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd31};
        esel = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};

        A1 = 5'd12; A2 = 5'd0; WD = 32'd0; WE = 1'b0; PC = 32'd0;
        BD = 1'b0; ExcCode = 5'd0; EXLSet = 1'b1; EXLClr = 1'b0; HWInt = '0;
        do_reset();

        // Interrupt entry
        A2 = 5'd12; WD = 32'h0000_FC01; WE = 1'b1;
        cycle("sr_wr");
        WE = 1'b0; HWInt = 6'b000100; PC = 32'h0000_3008; A1 = 5'd12;
        #1;
        check("sr_rd", RD, 32'h0000_FC01);
        check("irq_not_yet", 32'(IntReq), 32'd0);
        cycle("hw_rise");
        check("irq_entry", 32'(IntReq), 32'd1);
        cycle("irq_take");
        check("entry_epc", EPC, 32'h0000_3008);
        check("entry_intreq_drop", 32'(IntReq), 32'd0);
        A1 = 5'd13;
        #1;
        check("entry_cause", RD, 32'h0000_1000);
        A1 = 5'd12;
        #1;
        check("entry_sr_exl", RD, 32'h0000_FC03);
        cycle("in_handler");

        // Collision: exception edge discards concurrent mtc0 to EPC
        EXLClr = 1'b1;
        cycle("eret1");
        EXLClr = 1'b0;
        #1;
        check("collide_irq", 32'(IntReq), 32'd1);
        WE = 1'b1; A2 = 5'd14; WD = 32'hDEAD_BEEF; PC = 32'h4000_0012;
        cycle("collide");
        WE = 1'b0;
        check("collide_epc", EPC, 32'h4000_0010);

        // Masking by IE and by IM
        HWInt = '0; EXLClr = 1'b1;
        cycle("eret2");
        EXLClr = 1'b0;
        WE = 1'b1; A2 = 5'd12; WD = 32'h0000_FC00; HWInt = 6'b000100;
        cycle("ie_off_wr");
        WE = 1'b0;
        cycle("ie_off");
        A1 = 5'd13;
        #1;
        check("mask_ie_irq", 32'(IntReq), 32'd0);
        check("mask_ie_cause", RD, 32'h0000_1000);
        WE = 1'b1; WD = 32'h0000_EC01;
        cycle("im_off_wr");
        WE = 1'b0;
        cycle("im_off");
        check("mask_im_irq", 32'(IntReq), 32'd0);

        // Synchronous exception and eret
        HWInt = '0; WE = 1'b1; WD = 32'h0000_0001;
        cycle("sync_sr");
        WE = 1'b0;
        cycle("sync_idle");
        EXLSet = 1'b1; ExcCode = 5'(EXC_OV); BD = 1'b1;
        #1;
        check("sync_irq", 32'(IntReq), 32'd1);
        cycle("sync_take");
        EXLSet = 1'b0; BD = 1'b0; A1 = 5'd13;
        #1;
        check("sync_cause", RD, 32'h8000_0030);
        A1 = 5'd12;
        #1;
        check("sync_sr", RD, 32'h0000_0003);
        EXLClr = 1'b1;
        cycle("sync_eret");
        EXLClr = 1'b0;
        #1;
        check("eret_exl", RD, 32'h0000_0001);

        // Asynchronous reset in the middle of an exception
        EXLSet = 1'b1;
        cycle("pre_abort");
        A1 = 5'd12;
        #1;
        check("pre_abort_exl", RD & 32'd2, 32'd2);
        do_reset();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            A1 = rsel[$urandom_range(7)];
            A2 = rsel[$urandom_range(7)];
            WE = ($urandom_range(3) == 0);
            WD = $urandom;
`ifdef CP0_TIMER_EN
            if (A2 == 5'd11 && $urandom_range(1) == 1) WD = m_count + 32'($urandom_range(6));
`endif
            PC      = $urandom;
            BD      = 1'($urandom_range(1));
            ExcCode = esel[$urandom_range(4)];
            EXLSet  = ($urandom_range(9) == 0);
            EXLClr  = m_sr[1] && ($urandom_range(3) == 0);
            if (EXLClr && A2 == 5'd12) WE = 1'b0;
            if ($urandom_range(3) == 0) HWInt = NUM_HWINT'($urandom);
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cp0_int_ctrl
`default_nettype wire

// File: doc/cp0_int_ctrl.md
CP0_INT_CTRL -- requirements
Module: cp0_int_ctrl

Interface
REQ-001 SHALL have parameter NUM_HWINT, default 6: number of hardware interrupt lines, legal 1..8 (1..7 with CP0_TIMER_EN).
REQ-002 SHALL have parameter PRID_VAL, default 32'h0000_1234: read-only processor ID value.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- A1  in  5  CP0 read register number.
- A2  in  5  CP0 write register number.
- WD  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable.
- PC  in  32  victim PC presented by the M stage.
- BD  in  1  victim is in a delay slot.
- ExcCode  in  5  synchronous exception code.
- EXLSet  in  1  synchronous exception request.
- EXLClr  in  1  eret; clears EXL.
- HWInt  in  NUM_HWINT  level interrupt lines.
- IntReq  out  1  take exception now; flush the pipeline.
- EPC  out  32  EPC register.
- RD  out  32  read data for A1.

Function
REQ-004 SHALL implement registers SR(12), Cause(13), EPC(14), PRId(15), Count(9) and Compare(11); all other numbers SHALL read 0 and ignore writes.
REQ-005 SR fields SHALL be IM[9+NUM_HWINT(+1 with timer):10], EXL bit 1 and IE bit 0; all other bits SHALL read 0.
REQ-006 Cause fields SHALL be BD bit 31, IP at the IM bit positions, and ExcCode[6:2].
REQ-007 IP SHALL register HWInt every cycle, giving 1 cycle of latency from HWInt to IP.
REQ-008 IntReq SHALL be combinational: ((|(IP & IM)) & IE & !EXL) | (EXLSet & !EXL).
REQ-009 On a clock edge with IntReq=1, the block SHALL:
- load EPC <= {PC[31:2],2'b00}.
- load Cause.BD <= BD.
- set EXL <= 1.
- load Cause.ExcCode <= 0 if an interrupt is pending, else ExcCode.
REQ-010 Interrupt SHALL take priority over EXLSet in the same cycle.
REQ-011 On a clock edge with IntReq=1, a simultaneous mtc0 write SHALL be discarded.
REQ-012 EXLClr SHALL clear EXL at the next edge; EXLClr with IntReq=1 cannot occur (EXL=1 forces IntReq=0).
REQ-013 mtc0 SHALL write SR (IM/EXL/IE only), EPC (low 2 bits forced 0), Count and Compare; writes to Cause and PRId SHALL be ignored.
REQ-014 RD SHALL be combinational on A1; Cause SHALL read the current registered IP.
REQ-015 A write and a read of the same register in one cycle SHALL return the old value; no internal bypass.
REQ-016 EPC output SHALL equal the EPC register and SHALL be valid the cycle after the write.

Reset
REQ-017 On reset low, asynchronously: SR=0, Cause=0, EPC=0, Count=0, Compare=32'hFFFF_FFFF, timer flag=0, IP=0.
REQ-018 IntReq SHALL be 0 during reset.
REQ-019 On reset deassertion, registers SHALL change only on the next rising clk.
REQ-020 A reset arriving mid-exception SHALL abort it, with EXL=0 afterwards.

Configuration
REQ-021 Macro CP0_TIMER_EN defined: Count SHALL increment every cycle, wrapping 32'hFFFF_FFFF->0.
REQ-022 Timer flag behaviour with CP0_TIMER_EN:
- The flag SHALL set on the edge after Count==Compare.
- The flag SHALL clear on an mtc0 to Compare (clear wins over a simultaneous set).
- The flag SHALL appear as IP bit 10+NUM_HWINT, masked by the matching IM bit.
REQ-023 Macro CP0_TIMER_EN undefined: Count and Compare SHALL read 0 and ignore writes, and no timer logic SHALL exist.

Structure
REQ-024 Shared package cp0_pkg SHALL hold the register number constants, SR/Cause bit positions and ExcCode enumeration (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
REQ-025 Timer SHALL be sub-module cp0_timer (Count, Compare, flag).
REQ-026 The remainder SHALL be flat.

Verification
REQ-027 Interrupt entry: SR=32'h0000_FC01, HWInt[2] rises, PC=32'h0000_3008 -> IntReq=1 one cycle later; next edge EPC=32'h3008, EXL=1, Cause.ExcCode=0; IntReq drops.
REQ-028 Masking: IE=0 or IM[12]=0 with HWInt[2]=1 -> IntReq stays 0; Cause reads 32'h0000_1000.
REQ-029 Same-cycle collision: IntReq=1 with WE=1, A2=14, WD=32'hDEAD_BEEF -> EPC=PC, not 32'hDEADBEEC.
REQ-030 Sync exception: EXLSet=1, ExcCode=12, BD=1 -> Cause=32'h8000_0030; eret -> EXL=0 next edge.
REQ-031 Timer (CP0_TIMER_EN): Compare=5 after reset, IM timer bit and IE set -> flag and IntReq at cycle 6; mtc0 Compare clears both.
REQ-032 Async reset asserted mid-cycle with EXL=1 -> all registers at reset values immediately, with no clock needed.
